// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
// Widths follow the core's XLEN/ADDR_SIZE.
package mem_port_arbiter_pkg;
   localparam int XLEN      = 32;
   localparam int ADDR_SIZE = 32;
   localparam logic [3:0] AMP_FULL = 4'b1111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } arb_owner_t;
endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating count of data grants won while fetch was waiting; force_if
// tells the arbiter that fetch must win the next conflict.
module arb_starve_ctr #(
   parameter int MAX_WAIT = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic sample,
   input  logic if_req,
   input  logic if_grant,
   input  logic dm_grant,
   output logic force_if
);
   localparam int W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [W-1:0] SAT = W'(MAX_WAIT);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset)
         cnt <= '0;
      else if (sample) begin
         if (if_grant || !if_req)
            cnt <= '0;
         else if (dm_grant && cnt != SAT)
            cnt <= cnt + W'(1);
      end
   end

   assign force_if = (cnt == SAT);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data ports, one access at a time.
// Optional MEM_ARB_PERF_CNT_EN adds grant/conflict performance counters.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int MAX_WAIT = 3,
   parameter int TIMEOUT  = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 if_req,
   input  logic [ADDR_SIZE-1:0] if_addr,
   output logic [XLEN-1:0]      if_rdata,
   output logic                 if_ready,
   input  logic                 dm_req,
   input  logic                 dm_we,
   input  logic [3:0]           dm_amp,
   input  logic [ADDR_SIZE-1:0] dm_addr,
   input  logic [XLEN-1:0]      dm_wdata,
   output logic [XLEN-1:0]      dm_rdata,
   output logic                 dm_ready,
`ifdef MEM_ARB_PERF_CNT_EN
   output logic [31:0]          perf_if_grants,
   output logic [31:0]          perf_dm_grants,
   output logic [31:0]          perf_conflicts,
`endif
   output logic                 m_en,
   output logic                 m_we,
   output logic [3:0]           m_amp,
   output logic [ADDR_SIZE-1:0] m_addr,
   output logic [XLEN-1:0]      m_wdata,
   input  logic [XLEN-1:0]      m_rdata,
   input  logic                 m_valid,
   output logic                 busy,
   output logic                 err
);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

   arb_state_t    state;
   arb_owner_t    owner;
   logic [TW-1:0] wait_cnt;
   logic          sample, force_if, grant_dm, grant_if;

   assign sample   = (state == IDLE);
   assign grant_dm = dm_req && !(if_req && force_if);
   assign grant_if = if_req && !grant_dm;

   arb_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve (
      .clk      (clk),
      .reset    (reset),
      .sample   (sample),
      .if_req   (if_req),
      .if_grant (grant_if),
      .dm_grant (grant_dm),
      .force_if (force_if)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         owner    <= OWN_IF;
         wait_cnt <= '0;
         m_en     <= 1'b0;
         m_we     <= 1'b0;
         m_amp    <= '0;
         m_addr   <= '0;
         m_wdata  <= '0;
         if_rdata <= '0;
         if_ready <= 1'b0;
         dm_rdata <= '0;
         dm_ready <= 1'b0;
         busy     <= 1'b0;
         err      <= 1'b0;
      end else begin
         m_en     <= 1'b0;
         if_ready <= 1'b0;
         dm_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_dm) begin
                  owner   <= OWN_DM;
                  m_we    <= dm_we;
                  m_amp   <= dm_amp;
                  m_addr  <= dm_addr;
                  m_wdata <= dm_wdata;
                  m_en    <= 1'b1;
                  busy    <= 1'b1;
                  state   <= ISSUE;
               end else if (grant_if) begin
                  owner   <= OWN_IF;
                  m_we    <= 1'b0;
                  m_amp   <= AMP_FULL;
                  m_addr  <= if_addr;
                  m_wdata <= '0;
                  m_en    <= 1'b1;
                  busy    <= 1'b1;
                  state   <= ISSUE;
               end
            end
            ISSUE: begin
               wait_cnt <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               // A response arriving on the last allowed cycle still counts as success.
               if (m_valid || wait_cnt == TLAST) begin
                  if (owner == OWN_DM) begin
                     dm_rdata <= m_valid ? m_rdata : '0;
                     dm_ready <= 1'b1;
                  end else begin
                     if_rdata <= m_valid ? m_rdata : '0;
                     if_ready <= 1'b1;
                  end
                  if (!m_valid) err <= 1'b1;
                  state <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + TW'(1);
               end
            end
            RESP: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MEM_ARB_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         perf_if_grants <= '0;
         perf_dm_grants <= '0;
         perf_conflicts <= '0;
      end else if (sample) begin
         if (grant_if)         perf_if_grants <= perf_if_grants + 32'd1;
         if (grant_dm)         perf_dm_grants <= perf_dm_grants + 32'd1;
         if (if_req && dm_req) perf_conflicts <= perf_conflicts + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level reference model.
// Define MEM_ARB_PERF_CNT_EN to also check the performance counters.
module tb_mem_port_arbiter;
   localparam int MAX_WAIT = 3;
   localparam int TIMEOUT  = 15;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        if_req = 1'b0, if_ready;
   logic [31:0] if_addr = '0, if_rdata;
   logic        dm_req = 1'b0, dm_we = 1'b0, dm_ready;
   logic [3:0]  dm_amp = '0;
   logic [31:0] dm_addr = '0, dm_wdata = '0, dm_rdata;
   logic        m_en, m_we, m_valid = 1'b0, busy, err;
   logic [3:0]  m_amp;
   logic [31:0] m_addr, m_wdata, m_rdata = '0;
`ifdef MEM_ARB_PERF_CNT_EN
   logic [31:0] perf_if_grants, perf_dm_grants, perf_conflicts;
`endif

   mem_port_arbiter #(.MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .dm_req(dm_req), .dm_we(dm_we), .dm_amp(dm_amp), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
`ifdef MEM_ARB_PERF_CNT_EN
      .perf_if_grants(perf_if_grants), .perf_dm_grants(perf_dm_grants),
      .perf_conflicts(perf_conflicts),
`endif
      .m_en(m_en), .m_we(m_we), .m_amp(m_amp), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_valid(m_valid), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   int errors = 0, checks = 0;

   // reference model state
   int          starve = 0;
   logic [31:0] exp_if_rdata = '0, exp_dm_rdata = '0;
   logic        exp_err = 1'b0;
   int          n_if = 0, n_dm = 0, n_conf = 0;
   logic        obs_dm;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic new_if();
      if_req  = 1'b1;
      if_addr = $urandom & 32'hFFFF_FFFC;
   endtask

   task automatic new_dm();
      dm_req   = 1'b1;
      dm_we    = 1'($urandom_range(0, 1));
      dm_amp   = 4'($urandom_range(0, 15));
      dm_addr  = $urandom;
      dm_wdata = $urandom;
   endtask

   // Called at the negedge of an idle cycle with at least one request high.
   task automatic run_txn(input int lat, input bit tmo, input logic [31:0] rd, input int p_again);
      bit          win_dm;
      logic        e_we;
      logic [3:0]  e_amp;
      logic [31:0] e_addr, e_wd, e_rd;
      int          nwait;
      win_dm = dm_req && !(if_req && starve == MAX_WAIT);
      if (if_req && dm_req) n_conf++;
      if (win_dm) begin
         n_dm++;
         starve = if_req ? ((starve < MAX_WAIT) ? starve + 1 : MAX_WAIT) : 0;
      end else begin
         n_if++;
         starve = 0;
      end
      e_we   = win_dm ? dm_we : 1'b0;
      e_amp  = win_dm ? dm_amp : 4'b1111;
      e_addr = win_dm ? dm_addr : if_addr;
      e_wd   = dm_wdata;

      step();  // ISSUE cycle
      chk("m_en_issue", m_en, 1);
      chk("busy_issue", busy, 1);
      chk("m_we", m_we, e_we);
      chk("m_amp", m_amp, e_amp);
      chk("m_addr", m_addr, e_addr);
      if (win_dm) chk("m_wdata", m_wdata, e_wd);
      chk("ready_issue", {if_ready, dm_ready}, 0);
      // stray response and field changes here must have no effect
      m_valid = 1'($urandom_range(0, 1));
      m_rdata = $urandom;
      if (win_dm) dm_addr = $urandom; else if_addr = $urandom;
      if (!if_req && $urandom_range(0, 1) == 1) new_if();
      if (!dm_req && $urandom_range(0, 1) == 1) new_dm();

      nwait = tmo ? TIMEOUT : lat;
      for (int k = 1; k <= nwait; k++) begin
         step();  // WAIT cycle k
         chk("m_en_wait", m_en, 0);
         chk("m_addr_hold", m_addr, e_addr);
         chk("ready_wait", {if_ready, dm_ready}, 0);
         chk("busy_wait", busy, 1);
         m_valid = (!tmo && k == lat);
         m_rdata = rd;
      end
      step();  // RESP cycle
      m_valid = 1'b0;
      e_rd = tmo ? 32'h0 : rd;
      if (tmo) exp_err = 1'b1;
      if (win_dm) exp_dm_rdata = e_rd; else exp_if_rdata = e_rd;
      obs_dm = dm_ready;
      chk("if_ready", if_ready, !win_dm);
      chk("dm_ready", dm_ready, win_dm);
      chk("if_rdata", if_rdata, exp_if_rdata);
      chk("dm_rdata", dm_rdata, exp_dm_rdata);
      chk("err", err, exp_err);
      chk("busy_resp", busy, 1);
      if (tmo) begin
         m_valid = 1'b1;
         m_rdata = 32'hBAD0_BAD0;
      end
      if (win_dm) begin
         if ($urandom_range(0, 99) < p_again) new_dm(); else dm_req = 1'b0;
      end else begin
         if ($urandom_range(0, 99) < p_again) new_if(); else if_req = 1'b0;
      end
      step();  // idle cycle
      m_valid = 1'b0;
      chk("busy_idle", busy, 0);
      chk("m_en_idle", m_en, 0);
      chk("ready_idle", {if_ready, dm_ready}, 0);
      chk("rdata_keep", if_rdata ^ dm_rdata, exp_if_rdata ^ exp_dm_rdata);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      step();
      step();
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_m_en", m_en, 0);
      chk("rst_ready", {if_ready, dm_ready}, 0);
      chk("rst_rdata", if_rdata | dm_rdata, 0);
      chk("rst_m_addr", m_addr, 0);
      reset = 1'b1;
      step();

      // lone fetch, single-cycle memory
      if_req = 1'b1;
      if_addr = 32'h0000_0010;
      run_txn(1, 1'b0, 32'h0050_0093, 0);
      chk("dir_fetch_rdata", if_rdata, 32'h0050_0093);

      // store and fetch raised together: store goes first
      if_req = 1'b1; if_addr = 32'h0000_0020;
      dm_req = 1'b1; dm_we = 1'b1; dm_amp = 4'b0011;
      dm_addr = 32'h0000_0100; dm_wdata = 32'hDEAD_BEEF;
      run_txn(1, 1'b0, 32'h0, 0);
      chk("dir_first_dm", obs_dm, 1);
      run_txn(2, 1'b0, $urandom, 0);
      chk("dir_then_if", obs_dm, 0);

      // both held continuously: dm dm dm if, repeating
      new_if();
      new_dm();
      for (int k = 0; k < 8; k++) begin
         run_txn($urandom_range(1, 3), 1'b0, $urandom, 100);
         chk("order", obs_dm, (k % 4) != 3);
      end
      if_req = 1'b0;
      dm_req = 1'b0;
      step();
      starve = 0;

      // memory never answers
      new_dm();
      run_txn(0, 1'b1, 32'h0, 0);
      chk("tmo_err", err, 1);
      chk("tmo_rdata", dm_rdata, 0);

      // random traffic
      for (int n = 0; n < 250; n++) begin
         if (!if_req && $urandom_range(0, 99) < 60) new_if();
         if (!dm_req && $urandom_range(0, 99) < 60) new_dm();
         if (!if_req && !dm_req) begin
            step();
            starve = 0;
            chk("idle_busy", busy, 0);
         end else begin
            run_txn($urandom_range(1, 4), $urandom_range(0, 24) == 0, $urandom, 50);
         end
      end

`ifdef MEM_ARB_PERF_CNT_EN
      chk("perf_if", perf_if_grants, n_if);
      chk("perf_dm", perf_dm_grants, n_dm);
      chk("perf_conf", perf_conflicts, n_conf);
`endif

      // reset during WAIT abandons the access
      if_req = 1'b0;
      new_dm();
      step();  // ISSUE
      step();  // WAIT
      reset = 1'b0;
      step();
      reset = 1'b1;
      dm_req = 1'b0;
      exp_err = 1'b0; exp_if_rdata = '0; exp_dm_rdata = '0;
      starve = 0; n_if = 0; n_dm = 0; n_conf = 0;
      chk("rstw_busy", busy, 0);
      chk("rstw_ready", {if_ready, dm_ready}, 0);
      chk("rstw_err", err, 0);
      chk("rstw_m_en", m_en, 0);
      m_valid = 1'b1;
      m_rdata = 32'h1234_5678;
      step();
      m_valid = 1'b0;
      chk("rstw_stray_ready", {if_ready, dm_ready}, 0);
      chk("rstw_stray_busy", busy, 0);
      chk("rstw_stray_rdata", dm_rdata, 0);
      step();
      chk("rstw_idle_ready", {if_ready, dm_ready}, 0);

      // traffic again after the abandoned access
      new_if();
      run_txn(1, 1'b0, $urandom, 0);
`ifdef MEM_ARB_PERF_CNT_EN
      chk("perf_if_post", perf_if_grants, n_if);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
